// File: rtl/rv32i_alu_pkg.sv
// Shared definitions for the RV32I ALU and its built-in self-test engine.
//   - ALU op encoding and width
//   - LFSR / MISR polynomial constants
//   - alu_ref: golden ALU model (also used by the ALU bench scoreboard)
//   - lfsr_next / misr_next: single-step helpers for the BIST datapath
package rv32i_alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 4'b0100;

  // x^32+x^22+x^2+x+1, Galois form
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  // CRC-32 polynomial used for signature compression
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bist_state_e;

  function automatic logic [31:0] alu_ref(input logic [ALU_OP_W-1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Right-shifting Galois step: the bit shifted out of q[0] folds the taps back in.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q,
                                            input logic [31:0] poly);
    return q[0] ? ({1'b0, q[31:1]} ^ poly) : {1'b0, q[31:1]};
  endfunction

  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] din);
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ din;
  endfunction

endpackage

// File: rtl/rv32i_lfsr32.sv
// 32-bit Galois LFSR operand generator.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (state clears to 0)
//   i_load          load i_seed (priority over i_step)
//   i_seed          value loaded on i_load; must be nonzero for a useful sequence
//   i_step          advance one LFSR step
//   o_q             current register value
module rv32i_lfsr32
  import rv32i_alu_pkg::*;
#(
  parameter logic [31:0] POLY = LFSR_POLY
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_step,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_q <= '0;
    else if (i_load) r_q <= i_seed;
    else if (i_step) r_q <= lfsr_next(r_q, POLY);
  end

  assign o_q = r_q;

endmodule

// File: rtl/rv32i_alu_bist.sv
// Self-test engine for the combinational rv32i_alu.
// Drives op/a/b onto the ALU, compares the returned result against alu_ref,
// counts mismatches, records the first failing vector and compresses every
// sampled result into a MISR signature.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start               begin a run (only honoured in IDLE; wins over i_abort)
//   i_abort               leave RUN without done; current compare discarded
//   o_alu_op/a/b          registered ALU stimulus, held while IDLE
//   i_alu_result          ALU output, combinational from o_alu_op/a/b
//   o_busy                high in RUN
//   o_done                one-cycle pulse after the last compare
//   o_pass                no mismatches in the completed run; held until next start
//   o_err_count           saturating mismatch count
//   o_fail_op/a/b         stimulus of the first mismatch
//   o_signature           MISR over all results sampled in RUN
module rv32i_alu_bist
  import rv32i_alu_pkg::*;
#(
  parameter int          NUM_VECTORS = 64,
  parameter logic [31:0] SEED_A      = 32'hACE12468,
  parameter logic [31:0] SEED_B      = 32'h13579BDF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [31:0]         o_alu_a,
  output logic [31:0]         o_alu_b,
  input  logic [31:0]         i_alu_result,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [15:0]         o_err_count,
  output logic [ALU_OP_W-1:0] o_fail_op,
  output logic [31:0]         o_fail_a,
  output logic [31:0]         o_fail_b,
  output logic [31:0]         o_signature
);

  localparam int             VEC_W    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);

  bist_state_e         r_state, w_state_nxt;
  logic [ALU_OP_W-1:0] r_op;
  logic [VEC_W-1:0]    r_vec;
  logic [15:0]         r_err_count;
  logic [ALU_OP_W-1:0] r_fail_op;
  logic [31:0]         r_fail_a, r_fail_b;
  logic [31:0]         r_sig;
  logic                r_done, r_pass;

  logic        w_load, w_cmp, w_fin, w_last, w_step, w_mis;
  logic [15:0] w_err_nxt;
  logic [31:0] w_a, w_b;

  assign w_last = (r_op == OP_XOR) && (r_vec == VEC_LAST);
  assign w_mis  = w_cmp && (i_alu_result != alu_ref(r_op, w_a, w_b));
  assign w_err_nxt = (w_mis && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1 : r_err_count;
  // The final compare leaves the operands on the bus rather than stepping past them.
  assign w_step = w_cmp && (r_op == OP_XOR) && !w_fin;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cmp       = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cmp = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_fin       = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- operand generators ----------------
  rv32i_lfsr32 #(.POLY(LFSR_POLY)) u_lfsr_a (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (w_load),
    .i_seed (SEED_A),
    .i_step (w_step),
    .o_q    (w_a)
  );

  rv32i_lfsr32 #(.POLY(LFSR_POLY)) u_lfsr_b (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (w_load),
    .i_seed (SEED_B),
    .i_step (w_step),
    .o_q    (w_b)
  );

  // ---------------- sequencing, compare, MISR ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op        <= '0;
      r_vec       <= '0;
      r_err_count <= '0;
      r_fail_op   <= '0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_sig       <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_op        <= OP_ADD;
        r_vec       <= '0;
        r_err_count <= '0;
        r_fail_op   <= '0;
        r_fail_a    <= '0;
        r_fail_b    <= '0;
        r_sig       <= '0;
        r_pass      <= 1'b0;
      end else if (w_cmp) begin
        r_sig       <= misr_next(r_sig, i_alu_result);
        r_err_count <= w_err_nxt;
        if (w_mis && (r_err_count == 16'h0)) begin
          r_fail_op <= r_op;
          r_fail_a  <= w_a;
          r_fail_b  <= w_b;
        end
        if (w_fin) begin
          r_done <= 1'b1;
          r_pass <= (w_err_nxt == 16'h0);
        end else if (r_op == OP_XOR) begin
          r_op  <= OP_ADD;
          r_vec <= r_vec + VEC_W'(1);
        end else begin
          r_op <= r_op + ALU_OP_W'(1);
        end
      end
    end
  end

  assign o_alu_op    = r_op;
  assign o_alu_a     = w_a;
  assign o_alu_b     = w_b;
  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = r_err_count;
  assign o_fail_op   = r_fail_op;
  assign o_fail_a    = r_fail_a;
  assign o_fail_b    = r_fail_b;
  assign o_signature = r_sig;

endmodule

// File: doc/rv32i_alu_bist.md
# rv32i_alu_bist

Self-test engine for the combinational `rv32i_alu`: it drives `op`/`a`/`b` into the ALU, checks `result` against an internal reference model and compresses all results into a signature. It sits beside the ALU in the core, muxed onto the ALU inputs during test, and replaces bench-driven ALU stimulus with an on-chip pass/fail result.

## Interface
Parameters:
- `NUM_VECTORS`, 64: operand pairs applied; each pair is run through all 5 ops; legal range 1..4096.
- `SEED_A`, 32'hACE12468: initial value of operand-A LFSR; must be nonzero.
- `SEED_B`, 32'h13579BDF: initial value of operand-B LFSR; must be nonzero.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  stop a run; return to IDLE without `done`.
- `alu_op`  out  4  registered op to ALU.
- `alu_a`  out  32  registered operand A.
- `alu_b`  out  32  registered operand B.
- `alu_result`  in  32  ALU output, combinational from `alu_op`/`alu_a`/`alu_b`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last compare.
- `pass`  out  1  err_count==0 at completion; held until next `start`.
- `err_count`  out  16  mismatches, saturating at 16'hFFFF.
- `fail_op`  out  4  op of first mismatch.
- `fail_a`  out  32  A of first mismatch.
- `fail_b`  out  32  B of first mismatch.
- `signature`  out  32  MISR over every `alu_result` sampled in RUN.

## Operation
- Op encoding: 0000 ADD, 0001 SUB (a−b), 0010 AND, 0011 OR, 0100 XOR. Results are 32-bit with wrap-around and no carry/flags.
- Operands come from two 32-bit Galois LFSRs with polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003), loaded with SEED_A and SEED_B at `start`.
- Order: op is the inner loop (0→4), vector is the outer loop. After op 0100 both LFSRs step once and op returns to 0000.
- FSM states:
  - IDLE: `start` → RUN, loading op=0, a=SEED_A, b=SEED_B, clearing err_count, fail_*, pass and signature.
  - RUN: each cycle, compare `alu_result` with `alu_ref(alu_op, alu_a, alu_b)`, update the MISR, then advance.
    - On the 5·NUM_VECTORS-th compare → IDLE, pulse `done`, set `pass = (final err_count==0)`.
    - `abort` → IDLE; no `done`, `pass` stays 0; other status holds.
- Mismatch: err_count+1 (saturating). On the first mismatch only, capture fail_op/fail_a/fail_b.
- MISR update: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ alu_result.
- `start` in RUN is ignored. `abort` and `start` together in IDLE: `start` wins. `abort` in IDLE has no effect.
- In IDLE, `alu_op`/`alu_a`/`alu_b` hold their last values.

## Timing
- Reset values: every output is 0. State is IDLE.
- `start` sampled high at edge k → `busy`=1 and the first vector is on the ALU inputs after edge k.
- One compare per cycle. The last compare is at edge k+5·NUM_VECTORS. `done`=1 and `busy`=0 for the cycle after that edge.
- `err_count`, `signature` and `fail_*` are valid from the `done` cycle until the next `start`.
- `abort` sampled at edge j: that cycle's compare is discarded, and `busy`=0 after edge j.
- Reset asserted mid-run → immediately IDLE with all outputs 0. No `done` follows.

## Structure
- `rv32i_alu_pkg` holds:
  - op localparams and `ALU_OP_W`=4;
  - LFSR and MISR polynomial constants;
  - function `alu_ref`, shared with the ALU bench scoreboard.
- Sub-module `rv32i_lfsr32`, with `load`, `seed`, `step` and `q`. It is instantiated twice (A and B).
- FSM, counters, compare and MISR stay in the top.

## Test plan
- Good ALU, NUM_VECTORS=4, `start` pulse → first cycle has op=0000, a=ACE12468, b=13579BDF, result C038C047. `done` comes exactly 20 cycles after `start`, with pass=1 and err_count=0. The signature matches the bench model.
- Bench inverts result bit 0 whenever op=0010, NUM_VECTORS=4 → err_count=4, pass=0, fail_op=0010, fail_a=ACE12468, fail_b=13579BDF.
- `abort` at cycle 7 of the run → busy=0 next cycle and no `done` pulse. A new `start` then reproduces the scenario-1 signature.
- `start` pulsed again at cycle 3 of the run → ignored: still a single `done` at cycle 20 and an identical signature.
- `rst_n` low mid-run → all outputs 0 asynchronously. After release, the run reproduces scenario 1.
- Bench forces result=0 on every cycle with NUM_VECTORS=4096 → err_count=20480 (no saturation at this length). Saturation is checked separately by preloading err_count to 16'hFFFE: after two more mismatches it holds at 16'hFFFF.
